limn2600_assoc_cache: RTL and testbench
=======================================

LIMN2600_ASSOC_CACHE -- requirements
Module: limn2600_assoc_cache

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of one cached data word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning the byte-address width.
REQ-003 SHALL have parameter NUM_SETS, default 64, meaning the set count; it SHALL be a power of two ≥2.
REQ-004 SHALL have parameter NUM_WAYS, default 2, meaning the ways per set; it SHALL be a power of two, 1..8.
REQ-005 SHALL have one clock and a synchronous active-high reset: clk  in  1  clock, all state updates on posedge.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 req_valid  in  1  lookup request present.
REQ-008 req_ready  out  1  lookup can be accepted.
REQ-009 req_addr  in  ADDR_WIDTH  lookup byte address.
REQ-010 resp_valid  out  1  lookup result valid, a single-cycle pulse.
REQ-011 resp_hit  out  1  lookup hit.
REQ-012 resp_data  out  DATA_WIDTH  hit data; 0 on miss.
REQ-013 fill_valid  in  1  write a line.
REQ-014 fill_addr  in  ADDR_WIDTH  fill byte address.
REQ-015 fill_data  in  DATA_WIDTH  fill data.
REQ-016 flush  in  1  invalidate all entries.
REQ-017 busy  out  1  flush in progress.

Function
REQ-018 Address split SHALL be: bits [1:0] ignored; index = addr[IDX+1:2], where IDX = log2(NUM_SETS); tag = addr[ADDR_WIDTH-1:IDX+2].
REQ-019 Each entry SHALL hold a valid bit, a tag and a data word; each set SHALL hold a round-robin victim pointer of log2(NUM_WAYS) bits.
REQ-020 The FSM SHALL have the states IDLE and FLUSH; req_ready SHALL be 1 only in IDLE with rst low.
REQ-021 A lookup SHALL be accepted on req_valid&&req_ready; resp_valid, resp_hit and resp_data SHALL be registered and appear exactly 1 cycle later; one request per cycle SHALL be sustainable.
REQ-022 A hit SHALL require a valid entry with an equal tag in the indexed set; if several ways match, the lowest-numbered way SHALL win.
REQ-023 A fill whose tag already exists in the set SHALL overwrite that way, and the victim pointer SHALL stay unchanged.
REQ-024 Otherwise, a fill SHALL use the lowest invalid way; if all ways are valid, it SHALL use the victim way and then increment that set's pointer modulo NUM_WAYS.
REQ-025 A fill and a lookup to the same set in the same cycle SHALL see read-before-write: the lookup returns the pre-fill contents.
REQ-026 A flush in IDLE SHALL enter FLUSH and clear the valid bits of one set per cycle, from set 0 to NUM_SETS-1; after NUM_SETS cycles it SHALL return to IDLE; busy=1 throughout FLUSH.
REQ-027 flush asserted during FLUSH SHALL be ignored.
REQ-028 A fill during FLUSH SHALL be dropped.
REQ-029 flush and req_valid in the same IDLE cycle SHALL accept the request, which is answered from pre-flush contents, and then enter FLUSH.
REQ-030 A fill in the same cycle as flush assertion SHALL be dropped.
REQ-031 resp_valid SHALL be 0 in any cycle not following an accepted request.

Reset
REQ-032 When rst=1 at posedge, all valid bits, all victim pointers and the flush index SHALL clear to 0; the FSM SHALL go to IDLE; resp_valid, resp_hit and resp_data SHALL be 0; busy SHALL be 0.
REQ-033 Tag and data arrays SHALL not be cleared by reset.
REQ-034 Reset during FLUSH SHALL abort the flush, leaving all entries invalid.
REQ-035 A request accepted in the cycle before reset SHALL produce no response.

Configuration
REQ-036 Macro LIMN2600_CACHE_STATS_EN SHALL control the statistics feature.
REQ-037 With the macro defined, outputs hit_count and miss_count (32 bits each) SHALL exist, incrementing on each response with resp_hit=1 and resp_hit=0 respectively, saturating at 0xFFFFFFFF, cleared by reset and not cleared by flush.
REQ-038 Without the macro defined, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-039 Reset, then lookup 0x0000_1000 -> next cycle resp_valid=1, resp_hit=0, resp_data=0.
REQ-040 Fill 0x0000_1000 with 0xDEADBEEF, then lookup 0x0000_1000 -> hit, data 0xDEADBEEF; lookup 0x0000_1003 -> same hit.
REQ-041 Defaults: fill 0x000, 0x100, 0x200 (all set 0) with data 1, 2, 3 -> 0x000 misses, while 0x100 and 0x200 hit with data 2 and 3.
REQ-042 Fill 0x0000_0040 with 0x11, then refill the same address with 0x22 -> lookup hits with 0x22, and no other way in set 16 is consumed; a subsequent fill of 0x0000_0140 leaves 0x0000_0040 resident.
REQ-043 Populate 4 sets, pulse flush -> busy=1 and req_ready=0 for exactly 64 cycles, then all lookups miss; a fill issued mid-flush is absent afterward.
REQ-044 Same-cycle lookup and fill to 0x0000_0080 on an empty cache -> response is a miss; the next lookup of 0x0000_0080 hits.
REQ-045 With LIMN2600_CACHE_STATS_EN defined, 3 hits and 2 misses -> hit_count=3 and miss_count=2.

Source files
------------

// File: rtl/limn2600_assoc_cache.sv
// Set-associative lookup cache with per-set round-robin replacement and a
// sequential flush that invalidates one set per cycle.
// Optional hit/miss statistics counters: define LIMN2600_CACHE_STATS_EN.
module limn2600_assoc_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SETS   = 64,
  parameter int NUM_WAYS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [DATA_WIDTH-1:0] resp_data,
  input  logic                  fill_valid,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic                  flush,
  output logic                  busy
`ifdef LIMN2600_CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t state_q, state_d;

  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]      vptr_q  [NUM_SETS];
  logic [IDX_W-1:0]      flush_idx_q;

  logic [IDX_W-1:0]      req_idx, fill_idx;
  logic [TAG_W-1:0]      req_tag, fill_tag;
  logic                  accept_p0, fill_en;
  logic                  lk_hit_p0;
  logic [DATA_WIDTH-1:0] lk_data_p0;
  logic                  fill_match, fill_free, fill_rot;
  logic [WAY_W-1:0]      fill_mway, fill_fway, fill_way, vptr_next;
  logic                  unused_addr_bits;

  assign req_idx  = req_addr[IDX_W+1:2];
  assign req_tag  = req_addr[ADDR_WIDTH-1:IDX_W+2];
  assign fill_idx = fill_addr[IDX_W+1:2];
  assign fill_tag = fill_addr[ADDR_WIDTH-1:IDX_W+2];
  assign unused_addr_bits = ^{req_addr[1:0], fill_addr[1:0]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: a flush walks every set exactly once, extra flush pulses ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush) state_d = FLUSH;
      FLUSH:   if (flush_idx_q == IDX_W'(NUM_SETS - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs of the FSM; fills are refused while flushing or on the flush cycle
  always_comb begin
    req_ready = (state_q == IDLE) && !rst;
    busy      = (state_q == FLUSH);
    fill_en   = fill_valid && (state_q == IDLE) && !flush;
    accept_p0 = req_valid && req_ready;
  end

  // Lookup: scan from the top way down so the lowest-numbered match wins
  always_comb begin
    lk_hit_p0  = 1'b0;
    lk_data_p0 = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        lk_hit_p0  = 1'b1;
        lk_data_p0 = data_q[req_idx][w];
      end
    end
  end

  // Fill way choice: matching tag, else lowest invalid way, else the victim
  always_comb begin
    fill_match = 1'b0;
    fill_mway  = '0;
    fill_free  = 1'b0;
    fill_fway  = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[fill_idx][w] && (tag_q[fill_idx][w] == fill_tag)) begin
        fill_match = 1'b1;
        fill_mway  = WAY_W'(w);
      end
      if (!valid_q[fill_idx][w]) begin
        fill_free = 1'b1;
        fill_fway = WAY_W'(w);
      end
    end
    fill_rot  = !fill_match && !fill_free;
    fill_way  = fill_match ? fill_mway : (fill_free ? fill_fway : vptr_q[fill_idx]);
    vptr_next = (NUM_WAYS == 1) ? '0 : vptr_q[fill_idx] + 1'b1;
  end

  // Valid bits, victim pointers and flush cursor (cleared by reset)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        vptr_q[s]  <= '0;
      end
      flush_idx_q <= '0;
    end else if (state_q == FLUSH) begin
      valid_q[flush_idx_q] <= '0;
      flush_idx_q          <= flush_idx_q + 1'b1;
    end else if (fill_en) begin
      valid_q[fill_idx][fill_way] <= 1'b1;
      if (fill_rot) vptr_q[fill_idx] <= vptr_next;
    end
  end

  // Tag and data storage, written only by fills and never reset
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx][fill_way]  <= fill_tag;
      data_q[fill_idx][fill_way] <= fill_data;
    end
  end

  // p0 -> p1: registered response, data forced to zero on a miss
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_data  <= '0;
    end else begin
      resp_valid <= accept_p0;
      resp_hit   <= accept_p0 && lk_hit_p0;
      resp_data  <= (accept_p0 && lk_hit_p0) ? lk_data_p0 : '0;
    end
  end

`ifdef LIMN2600_CACHE_STATS_EN
  // Saturating hit/miss counters, advanced with each response, kept across flush
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept_p0) begin
      if (lk_hit_p0 && (hit_count != 32'hFFFF_FFFF))    hit_count  <= hit_count + 32'd1;
      if (!lk_hit_p0 && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_limn2600_assoc_cache.sv
// Directed bench for limn2600_assoc_cache: a vector table of fills/lookups
// plus hand-written sequences for flush, same-cycle and reset corner cases.
module tb_limn2600_assoc_cache;

  localparam int OP_RST  = 0;
  localparam int OP_FILL = 1;
  localparam int OP_LOOK = 2;

  typedef struct {
    int          op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        hit;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_hit;
  logic [31:0] resp_data;
  logic        fill_valid = 1'b0;
  logic [31:0] fill_addr = '0;
  logic [31:0] fill_data = '0;
  logic        flush = 1'b0;
  logic        busy;
`ifdef LIMN2600_CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  limn2600_assoc_cache dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .resp_valid(resp_valid),
    .resp_hit  (resp_hit),
    .resp_data (resp_data),
    .fill_valid(fill_valid),
    .fill_addr (fill_addr),
    .fill_data (fill_data),
    .flush     (flush),
    .busy      (busy)
`ifdef LIMN2600_CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t row(input int op, input logic [31:0] a, input logic [31:0] d,
                               input logic h, input logic [31:0] e);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.hit = h; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; fill_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_hit", 32'(resp_hit), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);
  endtask

  task automatic do_fill(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    fill_valid = 1'b1; fill_addr = a; fill_data = d;
    @(posedge clk);
    #1;
    fill_valid = 1'b0;
  endtask

  task automatic do_look(input string nm, input logic [31:0] a, input logic h, input logic [31:0] e);
    @(negedge clk);
    chk({nm, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = a;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk({nm, "_valid"}, 32'(resp_valid), 32'd1);
    chk({nm, "_hit"}, 32'(resp_hit), 32'(h));
    chk({nm, "_data"}, resp_data, e);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt;
    int ready_bad;
    int rv_seen;

    tbl.push_back(row(OP_RST,  32'h0,    32'h0,        1'b0, 32'h0));
    tbl.push_back(row(OP_LOOK, 32'h1000, 32'h0,        1'b0, 32'h0));
    tbl.push_back(row(OP_FILL, 32'h1000, 32'hDEADBEEF, 1'b0, 32'h0));
    tbl.push_back(row(OP_LOOK, 32'h1000, 32'h0,        1'b1, 32'hDEADBEEF));
    tbl.push_back(row(OP_LOOK, 32'h1003, 32'h0,        1'b1, 32'hDEADBEEF));
    tbl.push_back(row(OP_RST,  32'h0,    32'h0,        1'b0, 32'h0));
    tbl.push_back(row(OP_FILL, 32'h000,  32'h1,        1'b0, 32'h0));
    tbl.push_back(row(OP_FILL, 32'h100,  32'h2,        1'b0, 32'h0));
    tbl.push_back(row(OP_FILL, 32'h200,  32'h3,        1'b0, 32'h0));
    tbl.push_back(row(OP_LOOK, 32'h000,  32'h0,        1'b0, 32'h0));
    tbl.push_back(row(OP_LOOK, 32'h100,  32'h0,        1'b1, 32'h2));
    tbl.push_back(row(OP_LOOK, 32'h200,  32'h0,        1'b1, 32'h3));
    tbl.push_back(row(OP_FILL, 32'h300,  32'h4,        1'b0, 32'h0));
    tbl.push_back(row(OP_LOOK, 32'h100,  32'h0,        1'b0, 32'h0));
    tbl.push_back(row(OP_LOOK, 32'h200,  32'h0,        1'b1, 32'h3));
    tbl.push_back(row(OP_LOOK, 32'h300,  32'h0,        1'b1, 32'h4));
    tbl.push_back(row(OP_FILL, 32'h040,  32'h11,       1'b0, 32'h0));
    tbl.push_back(row(OP_FILL, 32'h040,  32'h22,       1'b0, 32'h0));
    tbl.push_back(row(OP_LOOK, 32'h040,  32'h0,        1'b1, 32'h22));
    tbl.push_back(row(OP_FILL, 32'h140,  32'h33,       1'b0, 32'h0));
    tbl.push_back(row(OP_LOOK, 32'h040,  32'h0,        1'b1, 32'h22));
    tbl.push_back(row(OP_LOOK, 32'h140,  32'h0,        1'b1, 32'h33));
    tbl.push_back(row(OP_FILL, 32'h240,  32'h44,       1'b0, 32'h0));
    tbl.push_back(row(OP_LOOK, 32'h040,  32'h0,        1'b0, 32'h0));
    tbl.push_back(row(OP_LOOK, 32'h240,  32'h0,        1'b1, 32'h44));
    tbl.push_back(row(OP_LOOK, 32'h140,  32'h0,        1'b1, 32'h33));
    tbl.push_back(row(OP_FILL, 32'h006,  32'h66,       1'b0, 32'h0));
    tbl.push_back(row(OP_LOOK, 32'h004,  32'h0,        1'b1, 32'h66));

    foreach (tbl[i]) begin
      case (tbl[i].op)
        OP_RST:  do_reset();
        OP_FILL: do_fill(tbl[i].addr, tbl[i].data);
        default: do_look($sformatf("vec%0d", i), tbl[i].addr, tbl[i].hit, tbl[i].exp);
      endcase
    end

    // Back-to-back lookups, then an idle cycle with no response
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h300;
    @(posedge clk); #1;
    chk("b2b0_valid", 32'(resp_valid), 32'd1);
    chk("b2b0_data", resp_data, 32'h4);
    req_addr = 32'h004;
    @(posedge clk); #1;
    chk("b2b1_valid", 32'(resp_valid), 32'd1);
    chk("b2b1_data", resp_data, 32'h66);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_resp", 32'(resp_valid), 32'd0);

    // Same-cycle lookup and fill to one set: lookup sees pre-fill contents
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h80;
    fill_valid = 1'b1; fill_addr = 32'h80; fill_data = 32'h88;
    @(posedge clk); #1;
    req_valid = 1'b0; fill_valid = 1'b0;
    chk("rbw_valid", 32'(resp_valid), 32'd1);
    chk("rbw_hit", 32'(resp_hit), 32'd0);
    chk("rbw_data", resp_data, 32'd0);
    do_look("rbw_after", 32'h80, 1'b1, 32'h88);

    // Flush with a mid-flush fill, flush re-pulse and request
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    cnt = 0; ready_bad = 0; rv_seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (resp_valid) rv_seen++;
      if (!busy) break;
      cnt++;
      if (req_ready) ready_bad++;
      if (c == 10) begin
        fill_valid = 1'b1; fill_addr = 32'h1000; fill_data = 32'h77;
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h300;
      end else if (c == 11) begin
        fill_valid = 1'b0; flush = 1'b0; req_valid = 1'b0;
      end
    end
    fill_valid = 1'b0; flush = 1'b0; req_valid = 1'b0;
    chk("flush_cycles", 32'(cnt), 32'd64);
    chk("flush_ready_low", 32'(ready_bad), 32'd0);
    chk("flush_no_resp", 32'(rv_seen), 32'd0);
    do_look("postflush_300", 32'h300, 1'b0, 32'h0);
    do_look("postflush_004", 32'h004, 1'b0, 32'h0);
    do_look("postflush_240", 32'h240, 1'b0, 32'h0);
    do_look("postflush_080", 32'h080, 1'b0, 32'h0);
    do_look("postflush_midfill", 32'h1000, 1'b0, 32'h0);

    // Flush together with a request and a fill
    do_fill(32'h80, 32'h55);
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h80;
    fill_valid = 1'b1; fill_addr = 32'h400; fill_data = 32'h9;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0; fill_valid = 1'b0;
    chk("fl_req_valid", 32'(resp_valid), 32'd1);
    chk("fl_req_hit", 32'(resp_hit), 32'd1);
    chk("fl_req_data", resp_data, 32'h55);
    chk("fl_req_busy", 32'(busy), 32'd1);
    wait_idle("fl_req");
    do_look("fl_fill_dropped", 32'h400, 1'b0, 32'h0);
    do_look("fl_req_cleared", 32'h80, 1'b0, 32'h0);

    // Reset in the middle of a flush
    do_fill(32'h80, 32'h5A);
    do_look("pre_abort", 32'h80, 1'b1, 32'h5A);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd1);
    do_reset();
    do_look("abort_after", 32'h80, 1'b0, 32'h0);

`ifdef LIMN2600_CACHE_STATS_EN
    do_reset();
    do_fill(32'h10, 32'h7);
    do_look("st_h0", 32'h10, 1'b1, 32'h7);
    do_look("st_h1", 32'h10, 1'b1, 32'h7);
    do_look("st_h2", 32'h10, 1'b1, 32'h7);
    do_look("st_m0", 32'h20, 1'b0, 32'h0);
    do_look("st_m1", 32'h20, 1'b0, 32'h0);
    chk("hit_count", hit_count, 32'd3);
    chk("miss_count", miss_count, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
